gendelayqueue_n: RTL and testbench

- Parametrised, bubble-collapsing shift-register delay queue built from flops only; no block RAM.
- Successor to the fixed 4-stage delay queue used between c2 pipeline stages.
- Adds: arbitrary DEPTH/WIDTH, occupancy count, programmable almost-full, synchronous flush, sticky overflow/underflow error flags.
- Items enter at the tail stage, advance one stage per cycle into empty or moving slots, and are presented at the head stage.

---
 rtl/gendelayqueue_n_if.sv | 30 +++
 rtl/gendelayqueue_n.sv | 81 ++++++++
 tb/tb_gendelayqueue_n.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/gendelayqueue_n_if.sv
// Handshake/bus bundle for the gendelayqueue_n delay queue.
// The master drives writes, reads and flush; the slave (the queue) returns head data and status.
interface gendelayqueue_n_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic             we;
    logic [WIDTH-1:0] idata;
    logic             re;
    logic             flush;
    logic [WIDTH-1:0] wdata;
    logic             oready;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output we, idata, re, flush,
        input  wdata, oready, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  we, idata, re, flush,
        output wdata, oready, full, empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/gendelayqueue_n.sv
// Bubble-collapsing shift-register delay queue: entries enter at stage 0 (tail),
// advance into empty or moving slots, and are presented at stage DEPTH-1 (head).
module gendelayqueue_n #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1),
    parameter int AFULL = DEPTH - 1
) (
    input logic               clk,
    input logic               rst,
    gendelayqueue_n_if.slave  q
);

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic [DEPTH-1:0] w_vacant;
    logic [DEPTH-1:0] w_mv;
    logic             w_wrAcc;
    logic             w_rdAcc;

    assign w_vacant = ~r_v;

    // A stage may advance when the head is being read or any stage at or above it
    // is empty; this is the unrolled form of the ripple move chain.
    always_comb begin
        w_mv = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_mv[i] = q.re | (|(w_vacant >> i));
        end
    end

    assign w_wrAcc = q.we & w_mv[0];
    assign w_rdAcc = q.re & r_v[DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v         <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= '0;
            end
        end else if (q.flush) begin
            r_v     <= '0;
            r_count <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (w_mv[i]) begin
                    r_v[i] <= r_v[i-1];
                    r_d[i] <= r_d[i-1];
                end
            end
            if (w_mv[0]) begin
                r_v[0] <= q.we;
                r_d[0] <= q.idata;
            end
            r_count <= r_count + CW'(w_wrAcc) - CW'(w_rdAcc);
            if (q.we && !w_mv[0]) begin
                r_overflow <= 1'b1;
            end
            if (q.re && !r_v[DEPTH-1]) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign q.wdata       = r_d[DEPTH-1];
    assign q.oready      = r_v[DEPTH-1];
    assign q.full        = r_v[0];
    assign q.empty       = ~(|r_v);
    assign q.count       = r_count;
    assign q.almost_full = (r_count >= CW'(AFULL));
    assign q.overflow    = r_overflow;
    assign q.underflow   = r_underflow;

endmodule

// File: tb/tb_gendelayqueue_n.sv
// Scoreboard bench for gendelayqueue_n (DEPTH=4, WIDTH=8): stimulus pushes expected
// head words, a negedge monitor pops and compares them whenever a read is consumed.
module tb_gendelayqueue_n;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst;

    gendelayqueue_n_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) q ();

    gendelayqueue_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW), .AFULL(DEPTH - 1)) dut (
        .clk (clk),
        .rst (rst),
        .q   (q.slave)
    );

    int               nChecks = 0;
    int               nFail   = 0;
    logic [WIDTH-1:0] sbQ [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: a read is consumed at the next edge whenever re meets a valid head.
    always @(negedge clk) begin
        logic [WIDTH-1:0] exp;
        if (!rst && !q.flush && q.re && q.oready) begin
            nChecks++;
            if (sbQ.size() == 0) begin
                nFail++;
                $display("[TB] FAIL pop_unexpected: got wdata=%02h, expected no entry", q.wdata);
            end else begin
                exp = sbQ.pop_front();
                if (q.wdata !== exp) begin
                    nFail++;
                    $display("[TB] FAIL pop_data: got wdata=%02h, expected %02h", q.wdata, exp);
                end
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic we, input logic [WIDTH-1:0] data,
                                 input logic re, input logic fl);
        q.we    = we;
        q.idata = data;
        q.re    = re;
        q.flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        rst = 1'b0;
        sbQ.delete();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        q.we    = 1'b0;
        q.idata = '0;
        q.re    = 1'b0;
        q.flush = 1'b0;

        // Reset with we held high: nothing may be captured.
        applyReset();
        checkOutput("rst_count", 32'(q.count), 0);
        checkOutput("rst_empty", 32'(q.empty), 1);
        checkOutput("rst_oready", 32'(q.oready), 0);
        checkOutput("rst_full", 32'(q.full), 0);
        checkOutput("rst_afull", 32'(q.almost_full), 0);
        checkOutput("rst_overflow", 32'(q.overflow), 0);
        checkOutput("rst_underflow", 32'(q.underflow), 0);
        checkOutput("rst_wdata", 32'(q.wdata), 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("rst_no_entry_oready", 32'(q.oready), 0);
        checkOutput("rst_no_entry_count", 32'(q.count), 0);

        // Latency: head valid exactly DEPTH edges after the write.
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("lat_oready_1", 32'(q.oready), 0);
        checkOutput("lat_count_1", 32'(q.count), 1);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            checkOutput("lat_oready", 32'(q.oready), (k == 3) ? 1 : 0);
            checkOutput("lat_count", 32'(q.count), 1);
        end
        checkOutput("lat_wdata", 32'(q.wdata), 32'hA5);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("lat_wdata_hold", 32'(q.wdata), 32'hA5);
        sbQ.push_back(8'hA5);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("lat_empty_after_read", 32'(q.empty), 1);

        // Fill and stall, then an overflowing fifth write.
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 8'(k), 1'b0, 1'b0);
            sbQ.push_back(8'(k));
            checkOutput("fill_count", 32'(q.count), 32'(k));
            checkOutput("fill_afull", 32'(q.almost_full), (k >= 3) ? 1 : 0);
            checkOutput("fill_full", 32'(q.full), 1);
        end
        checkOutput("fill_overflow_before", 32'(q.overflow), 0);
        applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
        checkOutput("fill_overflow", 32'(q.overflow), 1);
        checkOutput("fill_count_after_drop", 32'(q.count), 4);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("drain_count", 32'(q.count), 32'(3 - k));
        end
        checkOutput("drain_empty", 32'(q.empty), 1);
        checkOutput("drain_overflow_sticky", 32'(q.overflow), 1);

        applyReset();
        checkOutput("rst2_overflow", 32'(q.overflow), 0);

        // Streaming: one word in and one out per cycle once the head is valid.
        for (int i = 0; i < 104; i++) begin
            applyStimulus(1'b1, 8'(i + 1), (i >= 4) ? 1'b1 : 1'b0, 1'b0);
            sbQ.push_back(8'(i + 1));
            if (i >= 3) begin
                checkOutput("stream_count", 32'(q.count), 4);
            end
        end
        checkOutput("stream_overflow", 32'(q.overflow), 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("stream_empty", 32'(q.empty), 1);

        // Bubbles collapse behind the stalled head.
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
        sbQ.push_back(8'h10);
        sbQ.push_back(8'h20);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("bub_count", 32'(q.count), 2);
        checkOutput("bub_oready", 32'(q.oready), 1);
        checkOutput("bub_wdata", 32'(q.wdata), 32'h10);
        checkOutput("bub_full", 32'(q.full), 0);
        checkOutput("bub_s2_valid", 32'(dut.r_v), 32'hC);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("bub_empty", 32'(q.empty), 1);

        // Flush ignores same-cycle we/re and raises no flags.
        applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
        checkOutput("fl_count_loaded", 32'(q.count), 3);
        applyStimulus(1'b1, 8'h34, 1'b1, 1'b1);
        checkOutput("fl_count", 32'(q.count), 0);
        checkOutput("fl_empty", 32'(q.empty), 1);
        checkOutput("fl_overflow", 32'(q.overflow), 0);
        checkOutput("fl_underflow", 32'(q.underflow), 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("fl_no_ghost", 32'(q.oready), 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("uf_set", 32'(q.underflow), 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("uf_sticky_flush", 32'(q.underflow), 1);
        applyReset();
        checkOutput("uf_cleared_rst", 32'(q.underflow), 0);

        checkOutput("sb_drained", 32'(sbQ.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
